sdram_port_arbiter: RTL and testbench

- Shares the single SDRAM wishbone slave between two requesters: the CPU/video core wishbone master and the HPS ROM-download stream.
- The download stream delivers 16-bit halfwords; the core issues 32-bit classic and burst cycles.
- The block sequences grants, holds a grant across a core burst, and latches loader writes with a wait handshake back to hps_io.
- It also provides a bus watchdog so a lost ack cannot hang the SDRAM port.

---
 rtl/sdram_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Shares one wishbone SDRAM slave between the core master and the HPS ROM-download
// halfword stream; loader writes are latched behind ld_wait, and a watchdog aborts lost acks.
module sdram_port_arbiter #(
    parameter logic [25:0] LOAD_BASE = 26'h400000,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ram_ready,
    input  logic        core_stb,
    input  logic        core_cyc,
    input  logic        core_we,
    input  logic [3:0]  core_sel,
    input  logic [2:0]  core_cti,
    input  logic [21:0] core_adr,
    input  logic [31:0] core_dat,
    output logic        core_ack,
    input  logic        ld_en,
    input  logic        ld_wr,
    input  logic [23:0] ld_addr,
    input  logic [15:0] ld_dat,
    output logic        ld_wait,
    output logic        ram_stb,
    output logic        ram_cyc,
    output logic        ram_we,
    output logic [3:0]  ram_sel,
    output logic [25:0] ram_adr,
    output logic [31:0] ram_dat,
    output logic [2:0]  ram_cti,
    input  logic        ram_ack,
    output logic [1:0]  grant,
    output logic        overrun,
    output logic        timeout_err
);
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    // state | meaning:  IDLE | arbitrate, port parked;  CORE | core master owns port;  LOAD | latched loader write owns port
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CORE = 2'b01,
        ST_LOAD = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic            last_core_q, last_core_d;
    logic            pending_q, pending_d;
    logic [25:0]     hold_adr_q, hold_adr_d;
    logic [31:0]     hold_dat_q, hold_dat_d;
    logic [3:0]      hold_sel_q, hold_sel_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            overrun_q, overrun_d;
    logic            timeout_q, timeout_d;
    logic [25:0]     adr_q;
    logic [31:0]     dat_q;
    logic [3:0]      sel_q;

    logic core_req, ld_take, ld_drop, wd_expire, core_last_beat;
    logic unused_ld_lsb;

    assign unused_ld_lsb  = ld_addr[0];
    assign core_req       = core_cyc & core_stb;
    assign ld_take        = ld_wr & ld_en & ~pending_q;
    assign ld_drop        = ld_wr & ld_en & pending_q;
    assign wd_expire      = (state_q != ST_IDLE) & ~ram_ack & (wd_q == WD_W'(TIMEOUT - 1));
    assign core_last_beat = (core_cti == 3'b000) | (core_cti == 3'b111);

    assign grant       = state_q;
    assign ld_wait     = pending_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;

    always_comb begin
        ram_stb  = 1'b0;
        ram_cyc  = 1'b0;
        ram_we   = 1'b0;
        ram_cti  = 3'b000;
        ram_sel  = sel_q;
        ram_adr  = adr_q;
        ram_dat  = dat_q;
        core_ack = 1'b0;
        case (state_q)
            ST_CORE: begin
                ram_stb  = core_stb;
                ram_cyc  = core_cyc;
                ram_we   = core_we;
                ram_cti  = core_cti;
                ram_sel  = core_sel;
                ram_adr  = {2'b00, core_adr, 2'b00};
                ram_dat  = core_dat;
                core_ack = ram_ack;
            end
            ST_LOAD: begin
                ram_stb = 1'b1;
                ram_cyc = 1'b1;
                ram_we  = 1'b1;
                ram_sel = hold_sel_q;
                ram_adr = hold_adr_q;
                ram_dat = hold_dat_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        last_core_d = last_core_q;
        pending_d   = pending_q;
        hold_adr_d  = hold_adr_q;
        hold_dat_d  = hold_dat_q;
        hold_sel_d  = hold_sel_q;
        overrun_d   = overrun_q | ld_drop;
        timeout_d   = timeout_q;
        wd_d        = '0;

        if (ld_take) begin
            pending_d  = 1'b1;
            hold_adr_d = LOAD_BASE + {2'b00, ld_addr[23:2], 2'b00};
            hold_dat_d = {ld_dat, ld_dat};
            hold_sel_d = ld_addr[1] ? 4'b1100 : 4'b0011;
        end

        case (state_q)
            ST_IDLE: begin
                // On contention the requester that did not own the port last wins.
                if (ram_ready) begin
                    if (core_req && (!pending_q || !last_core_q))
                        state_d = ST_CORE;
                    else if (pending_q)
                        state_d = ST_LOAD;
                end
            end
            ST_CORE: begin
                if (!core_cyc || (ram_ack && core_last_beat)) begin
                    state_d     = ST_IDLE;
                    last_core_d = 1'b1;
                end else if (wd_expire) begin
                    state_d     = ST_IDLE;
                    last_core_d = 1'b1;
                    timeout_d   = 1'b1;
                end else if (!ram_ack) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_LOAD: begin
                if (ram_ack || wd_expire) begin
                    state_d     = ST_IDLE;
                    last_core_d = 1'b0;
                    pending_d   = 1'b0;
                    timeout_d   = timeout_q | wd_expire;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_core_q <= 1'b0;
            pending_q   <= 1'b0;
            hold_adr_q  <= '0;
            hold_dat_q  <= '0;
            hold_sel_q  <= '0;
            wd_q        <= '0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_core_q <= last_core_d;
            pending_q   <= pending_d;
            hold_adr_q  <= hold_adr_d;
            hold_dat_q  <= hold_dat_d;
            hold_sel_q  <= hold_sel_d;
            wd_q        <= wd_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            if (state_q != ST_IDLE) begin
                adr_q <= ram_adr;
                dat_q <= ram_dat;
                sel_q <= ram_sel;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against an ownership model holding loader writes in a queue.
module tb_sdram_port_arbiter;
    localparam int          TIMEOUT   = 255;
    localparam logic [25:0] LOAD_BASE = 26'h400000;

    logic        clk_sys = 1'b0, reset = 1'b1, ram_ready = 1'b0;
    logic        core_stb = 1'b0, core_cyc = 1'b0, core_we = 1'b0;
    logic [3:0]  core_sel = '0;
    logic [2:0]  core_cti = '0;
    logic [21:0] core_adr = '0;
    logic [31:0] core_dat = '0;
    logic        ld_en = 1'b0, ld_wr = 1'b0;
    logic [23:0] ld_addr = '0;
    logic [15:0] ld_dat = '0;
    logic        ram_ack = 1'b0;
    logic        core_ack, ld_wait, ram_stb, ram_cyc, ram_we, overrun, timeout_err;
    logic [3:0]  ram_sel;
    logic [25:0] ram_adr;
    logic [31:0] ram_dat;
    logic [2:0]  ram_cti;
    logic [1:0]  grant;
    logic        want_ack = 1'b0;

    sdram_port_arbiter #(.LOAD_BASE(LOAD_BASE), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys(clk_sys), .reset(reset), .ram_ready(ram_ready),
        .core_stb(core_stb), .core_cyc(core_cyc), .core_we(core_we), .core_sel(core_sel),
        .core_cti(core_cti), .core_adr(core_adr), .core_dat(core_dat), .core_ack(core_ack),
        .ld_en(ld_en), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_dat(ld_dat), .ld_wait(ld_wait),
        .ram_stb(ram_stb), .ram_cyc(ram_cyc), .ram_we(ram_we), .ram_sel(ram_sel),
        .ram_adr(ram_adr), .ram_dat(ram_dat), .ram_cti(ram_cti), .ram_ack(ram_ack),
        .grant(grant), .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_sys);
    endtask

    // SDRAM slave: acks only a strobed access, when the bench allows it.
    initial forever begin
        @(posedge clk_sys);
        #2;
        ram_ack = want_ack & ram_stb;
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [25:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } ldw_t;

    ldw_t        ldq[$];
    ldw_t        nw;
    int          m_own = 0, n_own = 0, m_wait = 0;
    bit          m_last_core = 1'b0, m_ovr = 1'b0, m_tmo = 1'b0, was_pend, creq;
    logic [25:0] m_padr = '0, e_adr;
    logic [3:0]  m_psel = '0, e_sel;
    logic [31:0] m_pdat = '0, e_dat;
    logic        e_stb, e_cyc, e_we, e_ack;
    logic [2:0]  e_cti;

    always @(negedge clk_sys) begin
        if (reset) begin
            m_own = 0; m_last_core = 1'b0; m_wait = 0; m_ovr = 1'b0; m_tmo = 1'b0;
            m_padr = '0; m_psel = '0; m_pdat = '0;
            ldq.delete();
        end
        e_stb = 0; e_cyc = 0; e_we = 0; e_cti = 0; e_ack = 0;
        e_adr = m_padr; e_sel = m_psel; e_dat = m_pdat;
        if (m_own == 1) begin
            e_stb = core_stb; e_cyc = core_cyc; e_we = core_we; e_cti = core_cti;
            e_adr = 26'(core_adr) << 2; e_sel = core_sel; e_dat = core_dat; e_ack = ram_ack;
        end else if (m_own == 2 && ldq.size() > 0) begin
            e_stb = 1; e_cyc = 1; e_we = 1;
            e_adr = ldq[0].adr; e_sel = ldq[0].sel; e_dat = ldq[0].dat;
        end
        chk("ram_stb", 32'(ram_stb), 32'(e_stb));
        chk("ram_cyc", 32'(ram_cyc), 32'(e_cyc));
        chk("ram_we", 32'(ram_we), 32'(e_we));
        chk("ram_cti", 32'(ram_cti), 32'(e_cti));
        chk("ram_adr", 32'(ram_adr), 32'(e_adr));
        chk("ram_sel", 32'(ram_sel), 32'(e_sel));
        chk("ram_dat", ram_dat, e_dat);
        chk("core_ack", 32'(core_ack), 32'(e_ack));
        chk("ld_wait", 32'(ld_wait), 32'(ldq.size() != 0));
        chk("grant", 32'(grant), 32'(m_own));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("timeout_err", 32'(timeout_err), 32'(m_tmo));

        if (!reset) begin
            was_pend = (ldq.size() != 0);
            n_own = m_own;
            if (m_own != 0) begin
                m_padr = e_adr; m_psel = e_sel; m_pdat = e_dat;
            end
            if (m_own == 0) begin
                creq = core_cyc && core_stb;
                if (ram_ready) begin
                    if (creq && was_pend) n_own = m_last_core ? 2 : 1;
                    else if (creq)        n_own = 1;
                    else if (was_pend)    n_own = 2;
                end
            end else if (m_own == 1) begin
                if (!core_cyc || (ram_ack && (core_cti == 3'd0 || core_cti == 3'd7))) begin
                    n_own = 0; m_last_core = 1'b1;
                end else if (!ram_ack && m_wait + 1 >= TIMEOUT) begin
                    n_own = 0; m_last_core = 1'b1; m_tmo = 1'b1;
                end
            end else begin
                if (ram_ack || m_wait + 1 >= TIMEOUT) begin
                    if (!ram_ack) m_tmo = 1'b1;
                    n_own = 0; m_last_core = 1'b0;
                    if (ldq.size() > 0) void'(ldq.pop_front());
                end
            end
            m_wait = (m_own != 0 && n_own == m_own && !ram_ack) ? m_wait + 1 : 0;
            if (ld_wr && ld_en) begin
                if (was_pend) m_ovr = 1'b1;
                else begin
                    nw.adr = LOAD_BASE + 26'(ld_addr / 4 * 4);
                    nw.dat = 32'(ld_dat) * 32'h0001_0001;
                    nw.sel = ((ld_addr / 2) % 2 == 1) ? 4'b1100 : 4'b0011;
                    ldq.push_back(nw);
                end
            end
            m_own = n_own;
        end
    end

    // ---------------- stimulus ----------------
    logic [1:0] rr_seq[8];
    int         rr_n, load_cycles, nz;
    logic [1:0] prev_g;

    initial begin
        repeat (3) tick();
        mid();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ld_wait", 32'(ld_wait), 32'd0);
        chk("rst_ram_adr", 32'(ram_adr), 32'd0);
        chk("rst_flags", {30'd0, overrun, timeout_err}, 32'd0);
        tick(); reset = 1'b0; ram_ready = 1'b1;

        // single loader write
        tick(); ld_en = 1; ld_wr = 1; ld_addr = 24'h000006; ld_dat = 16'hBEEF;
        tick(); ld_wr = 0;
        mid();
        chk("ld1_wait_set", 32'(ld_wait), 32'd1);
        chk("ld1_grant_idle", 32'(grant), 32'd0);
        tick(); mid();
        chk("ld1_grant", 32'(grant), 32'd2);
        chk("ld1_adr", 32'(ram_adr), 32'h0400004);
        chk("ld1_sel", 32'(ram_sel), 32'hC);
        chk("ld1_dat", ram_dat, 32'hBEEFBEEF);
        chk("ld1_we", 32'(ram_we), 32'd1);
        tick(); want_ack = 1; mid();
        chk("ld1_wait_during_ack", 32'(ld_wait), 32'd1);
        tick(); want_ack = 0; mid();
        chk("ld1_wait_clear", 32'(ld_wait), 32'd0);
        chk("ld1_grant_done", 32'(grant), 32'd0);

        // core burst with loader write raised mid-burst
        tick(); core_cyc = 1; core_stb = 1; core_cti = 3'b010; core_adr = 22'h000100;
        core_we = 1; core_sel = 4'hF; core_dat = 32'h11223344;
        tick(); mid();
        chk("burst_grant", 32'(grant), 32'd1);
        chk("burst_adr", 32'(ram_adr), 32'h0000400);
        for (int b = 0; b < 4; b++) begin
            tick(); want_ack = 1; core_cti = (b == 3) ? 3'b111 : 3'b010;
            ld_wr = (b == 1); ld_addr = 24'h000010; ld_dat = 16'h1234;
            mid();
            chk("burst_hold_grant", 32'(grant), 32'd1);
            chk("burst_core_ack", 32'(core_ack), 32'd1);
        end
        tick(); want_ack = 0; ld_wr = 0; core_cyc = 0; core_stb = 0; core_cti = 0; mid();
        chk("burst_idle_gap", 32'(grant), 32'd0);
        chk("burst_ld_waiting", 32'(ld_wait), 32'd1);
        tick(); mid();
        chk("burst_then_load", 32'(grant), 32'd2);
        chk("burst_load_adr", 32'(ram_adr), 32'h0400010);
        chk("burst_load_sel", 32'(ram_sel), 32'h3);
        chk("burst_load_dat", ram_dat, 32'h12341234);
        tick(); want_ack = 1;
        tick(); want_ack = 0; mid();
        chk("burst_load_done", 32'(grant), 32'd0);

        // round-robin under continuous demand
        tick(); core_cyc = 1; core_stb = 1; core_cti = 0; core_we = 0; want_ack = 1;
        ld_wr = 1; ld_addr = 24'h000020; ld_dat = 16'h0F0F;
        rr_n = 0; prev_g = 0;
        for (int i = 0; i < 24; i++) begin
            mid();
            if (grant != 0 && prev_g == 0 && rr_n < 8) begin
                rr_seq[rr_n] = grant;
                rr_n++;
            end
            prev_g = grant;
            tick(); ld_wr = !ld_wait; ld_addr = ld_addr + 24'd2;
        end
        chk("rr_segments", 32'(rr_n >= 6), 32'd1);
        for (int k = 0; k < 6; k++) chk("rr_alternate", 32'(rr_seq[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
        chk("rr_no_overrun", 32'(overrun), 32'd0);
        core_cyc = 0; core_stb = 0; ld_wr = 0;
        repeat (6) tick();
        want_ack = 0;

        // overrun: second halfword while the first is still pending
        tick(); ld_wr = 1; ld_addr = 24'h000102; ld_dat = 16'hA5A5;
        tick(); ld_wr = 1; ld_addr = 24'h000200; ld_dat = 16'h5A5A;
        tick(); ld_wr = 0; mid();
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_grant", 32'(grant), 32'd2);
        chk("ovr_first_adr", 32'(ram_adr), 32'h0400100);
        chk("ovr_first_dat", ram_dat, 32'hA5A5A5A5);
        tick(); want_ack = 1;
        tick(); want_ack = 0;
        repeat (3) tick();
        mid();
        chk("ovr_sticky", 32'(overrun), 32'd1);
        chk("ovr_dropped", 32'(ld_wait), 32'd0);

        // watchdog on a loader access
        tick(); ld_wr = 1; ld_addr = 24'h000008; ld_dat = 16'h7777;
        tick(); ld_wr = 0;
        load_cycles = 0;
        for (int i = 0; i < 300; i++) begin
            mid();
            if (grant == 2) load_cycles++;
            else if (load_cycles > 0) break;
            tick();
        end
        chk("wd_load_cycles", 32'(load_cycles), 32'd255);
        chk("wd_timeout_err", 32'(timeout_err), 32'd1);
        chk("wd_ld_wait", 32'(ld_wait), 32'd0);
        chk("wd_grant", 32'(grant), 32'd0);

        // asynchronous reset in the middle of a core burst
        tick(); core_cyc = 1; core_stb = 1; core_cti = 3'b010; want_ack = 1;
        tick(); mid();
        chk("rstb_grant_before", 32'(grant), 32'd1);
        tick(); #2; reset = 1; #1;
        chk("rstb_stb", 32'(ram_stb), 32'd0);
        chk("rstb_core_ack", 32'(core_ack), 32'd0);
        chk("rstb_grant", 32'(grant), 32'd0);
        tick(); ram_ready = 0; reset = 0;
        nz = 0;
        for (int i = 0; i < 10; i++) begin
            tick(); mid();
            if (grant != 0) nz++;
        end
        chk("rstb_no_grant_unready", 32'(nz), 32'd0);
        tick(); ram_ready = 1;
        tick(); mid();
        chk("rstb_grant_ready", 32'(grant), 32'd1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(7) == 0) core_cyc = !core_cyc;
            core_stb = ($urandom_range(3) != 0);
            case ($urandom_range(2))
                0:       core_cti = 3'b000;
                1:       core_cti = 3'b010;
                default: core_cti = 3'b111;
            endcase
            core_we   = 1'($urandom);
            core_sel  = 4'($urandom);
            core_adr  = 22'($urandom);
            core_dat  = $urandom;
            ld_en     = ($urandom_range(15) != 0);
            ld_wr     = ($urandom_range(5) == 0);
            ld_addr   = 24'($urandom);
            ld_dat    = 16'($urandom);
            ram_ready = ($urandom_range(31) != 0);
            want_ack  = ($urandom_range(3) != 0);
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
